// File: rtl/hash_table_stream_wrapper.sv
// Streaming front end for hash_table: 2-entry request skid, FWFT response FIFO, seq tags and stats.
// hash_table core: first-fit multi-table hash with bucketed slots and an overflow CAM; op[1]=delete, op[0]=write, else read.

module hash_table #(
  parameter int unsigned KEY_WIDTH           = 5,
  parameter int unsigned DATA_WIDTH          = 25,
  parameter int unsigned NUMBER_OF_TABLES    = 8,
  parameter int unsigned HASH_TABLE_MAX_SIZE = 5,
  parameter logic [NUMBER_OF_TABLES*32-1:0] HASH_TABLE_SIZES = {NUMBER_OF_TABLES{32'd5}},
  parameter int unsigned BUCKET_SIZE         = 2,
  parameter int unsigned CAM_SIZE            = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_i,
  input  logic [KEY_WIDTH-1:0]  key_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            delete_write_read_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  key_already_present,
  output logic                  no_element_found,
  output logic                  no_write_space,
  output logic                  no_deletion_target
);
  localparam int unsigned IW    = HASH_TABLE_MAX_SIZE;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned TW    = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;
  localparam int unsigned SW    = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
  localparam int unsigned CW    = (CAM_SIZE > 1) ? $clog2(CAM_SIZE) : 1;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;
  state_e state_q, state_d;
  logic   accept, ready_q, valid_q;

  logic                  tab_v_q [NUMBER_OF_TABLES][DEPTH][BUCKET_SIZE];
  logic [KEY_WIDTH-1:0]  tab_k_q [NUMBER_OF_TABLES][DEPTH][BUCKET_SIZE];
  logic [DATA_WIDTH-1:0] tab_d_q [NUMBER_OF_TABLES][DEPTH][BUCKET_SIZE];
  logic                  cam_v_q [CAM_SIZE];
  logic [KEY_WIDTH-1:0]  cam_k_q [CAM_SIZE];
  logic [DATA_WIDTH-1:0] cam_d_q [CAM_SIZE];

  logic [IW-1:0]         idx [NUMBER_OF_TABLES];
  logic                  hit_tab, hit_cam, free_tab, free_cam, hit;
  logic [TW-1:0]         hit_t, free_t;
  logic [SW-1:0]         hit_s, free_s;
  logic [CW-1:0]         hit_c, free_c;
  logic [DATA_WIDTH-1:0] hit_data, rdata_q;
  logic                  kap_q, nef_q, nws_q, ndt_q;

  // H3 hash per table; index bits above the table's own size are forced to zero
  always_comb begin
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      idx[t] = '0;
      for (int j = 0; j < IW; j++) begin
        if (j < int'(HASH_TABLE_SIZES[t*32 +: 32]))
          idx[t][j] = ^(key_in & matrixes_i[(t*IW + j)*KEY_WIDTH +: KEY_WIDTH]);
      end
    end
  end

  always_comb begin
    hit_tab  = 1'b0; hit_t  = '0; hit_s  = '0;
    free_tab = 1'b0; free_t = '0; free_s = '0;
    hit_cam  = 1'b0; hit_c  = '0;
    free_cam = 1'b0; free_c = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      for (int s = 0; s < BUCKET_SIZE; s++) begin
        if (tab_v_q[t][idx[t]][s] && (tab_k_q[t][idx[t]][s] == key_in) && !hit_tab) begin
          hit_tab = 1'b1; hit_t = TW'(t); hit_s = SW'(s);
        end
        if (!tab_v_q[t][idx[t]][s] && !free_tab) begin
          free_tab = 1'b1; free_t = TW'(t); free_s = SW'(s);
        end
      end
    end
    for (int c = 0; c < CAM_SIZE; c++) begin
      if (cam_v_q[c] && (cam_k_q[c] == key_in) && !hit_cam) begin
        hit_cam = 1'b1; hit_c = CW'(c);
      end
      if (!cam_v_q[c] && !free_cam) begin
        free_cam = 1'b1; free_c = CW'(c);
      end
    end
    hit      = hit_tab || hit_cam;
    hit_data = hit_tab ? tab_d_q[hit_t][idx[hit_t]][hit_s] : cam_d_q[hit_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_RESP);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (valid_i && ready_q) begin
        accept  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage update and result capture for the accepted operation
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUMBER_OF_TABLES; t++)
        for (int i = 0; i < DEPTH; i++)
          for (int s = 0; s < BUCKET_SIZE; s++)
            tab_v_q[t][i][s] <= 1'b0;
      for (int c = 0; c < CAM_SIZE; c++) cam_v_q[c] <= 1'b0;
      {kap_q, nef_q, nws_q, ndt_q} <= 4'b0;
      rdata_q <= '0;
    end else if (accept) begin
      {kap_q, nef_q, nws_q, ndt_q} <= 4'b0;
      rdata_q <= '0;
      if (delete_write_read_i[1]) begin
        if (hit_tab)      tab_v_q[hit_t][idx[hit_t]][hit_s] <= 1'b0;
        else if (hit_cam) cam_v_q[hit_c] <= 1'b0;
        else              ndt_q <= 1'b1;
      end else if (delete_write_read_i[0]) begin
        if (hit) begin
          kap_q <= 1'b1;
        end else if (free_tab) begin
          tab_v_q[free_t][idx[free_t]][free_s] <= 1'b1;
          tab_k_q[free_t][idx[free_t]][free_s] <= key_in;
          tab_d_q[free_t][idx[free_t]][free_s] <= data_in;
        end else if (free_cam) begin
          cam_v_q[free_c] <= 1'b1;
          cam_k_q[free_c] <= key_in;
          cam_d_q[free_c] <= data_in;
        end else begin
          nws_q <= 1'b1;
        end
      end else begin
        if (hit) rdata_q <= hit_data;
        else     nef_q   <= 1'b1;
      end
    end
  end

  assign ready_o             = ready_q;
  assign valid_o             = valid_q;
  assign read_data           = rdata_q;
  assign key_already_present = kap_q;
  assign no_element_found    = nef_q;
  assign no_write_space      = nws_q;
  assign no_deletion_target  = ndt_q;
endmodule

module hash_table_stream_wrapper #(
  parameter int unsigned KEY_WIDTH           = 5,
  parameter int unsigned DATA_WIDTH          = 25,
  parameter int unsigned NUMBER_OF_TABLES    = 8,
  parameter int unsigned HASH_TABLE_MAX_SIZE = 5,
  parameter logic [NUMBER_OF_TABLES*32-1:0] HASH_TABLE_SIZES = {NUMBER_OF_TABLES{32'd5}},
  parameter int unsigned BUCKET_SIZE         = 2,
  parameter int unsigned CAM_SIZE            = 8,
  parameter int unsigned OUT_WIDTH           = 64,
  parameter int unsigned SEQ_WIDTH           = 8,
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter int unsigned COUNT_WIDTH         = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_i,
  input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0]   data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic [OUT_WIDTH-1:0]                data_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  input  logic                                clear_stats_i,
  output logic [COUNT_WIDTH-1:0]              req_count_o,
  output logic [COUNT_WIDTH-1:0]              err_count_o,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o
);
  localparam int unsigned REQ_WIDTH = 2 + KEY_WIDTH + DATA_WIDTH;
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_WIDTH = PTR_WIDTH + 1;

  logic [REQ_WIDTH-1:0]  skid0_q, skid0_d, skid1_q, skid1_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic                  ready_q, ready_d, req_push, req_pop;

  logic                  ht_ready, ht_valid, ht_ready_in, resp_push, resp_pop;
  logic [DATA_WIDTH-1:0] ht_rdata;
  logic [3:0]            ht_flags;

  logic [OUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]  data_q, data_d, resp_word;
  logic                  valid_q, valid_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d, remain;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [COUNT_WIDTH-1:0] req_cnt_q, req_cnt_d, err_cnt_q, err_cnt_d;

  assign req_push = valid_i && ready_q;
  assign req_pop  = (skid_cnt_q != 2'd0) && ht_ready;

  // Skid: head in slot 0; ready reflects occupancy after this cycle's update
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (req_pop)                      skid0_d = (skid_cnt_q == 2'd2) ? skid1_q : data_i;
    else if (req_push && skid_cnt_q == 2'd0) skid0_d = data_i;
    else if (req_push)                skid1_d = data_i;
    case ({req_push, req_pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
    ready_d = (skid_cnt_d != 2'd2);
  end

  hash_table #(
    .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUMBER_OF_TABLES(NUMBER_OF_TABLES),
    .HASH_TABLE_MAX_SIZE(HASH_TABLE_MAX_SIZE), .HASH_TABLE_SIZES(HASH_TABLE_SIZES),
    .BUCKET_SIZE(BUCKET_SIZE), .CAM_SIZE(CAM_SIZE)
  ) u_hash_table (
    .clk                 (clk),
    .reset               (reset),
    .matrixes_i          (matrixes_i),
    .key_in              (skid0_q[DATA_WIDTH +: KEY_WIDTH]),
    .data_in             (skid0_q[DATA_WIDTH-1:0]),
    .delete_write_read_i (skid0_q[REQ_WIDTH-1 -: 2]),
    .valid_i             (skid_cnt_q != 2'd0),
    .ready_o             (ht_ready),
    .valid_o             (ht_valid),
    .ready_i             (ht_ready_in),
    .read_data           (ht_rdata),
    .key_already_present (ht_flags[3]),
    .no_element_found    (ht_flags[2]),
    .no_write_space      (ht_flags[1]),
    .no_deletion_target  (ht_flags[0])
  );

  assign ht_ready_in = (level_q < LVL_WIDTH'(FIFO_DEPTH));
  assign resp_push   = ht_valid && ht_ready_in;
  assign resp_pop    = valid_q && ready_i;

  always_comb begin
    resp_word = '0;
    resp_word[OUT_WIDTH-1 -: 4]         = ht_flags;
    resp_word[OUT_WIDTH-5 -: SEQ_WIDTH] = seq_q;
    resp_word[DATA_WIDTH-1:0]           = ht_rdata;
  end

  // FWFT FIFO with a registered head; the head only changes on pop or push-into-empty
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(resp_pop);
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(resp_push);
    level_d  = level_q + LVL_WIDTH'(resp_push) - LVL_WIDTH'(resp_pop);
    remain   = level_q - LVL_WIDTH'(resp_pop);
    data_d   = data_q;
    if (remain != '0)   data_d = mem_q[rd_ptr_d];
    else if (resp_push) data_d = resp_word;
    valid_d  = (level_d != '0);
    seq_d    = seq_q + SEQ_WIDTH'(resp_push);
  end

  always_comb begin
    req_cnt_d = req_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear_stats_i) begin
      req_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (req_push && req_cnt_q != '1) req_cnt_d = req_cnt_q + COUNT_WIDTH'(1);
      if (resp_push && (ht_flags != 4'b0) && err_cnt_q != '1) err_cnt_d = err_cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= 2'd0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      seq_q      <= '0;
      req_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      seq_q      <= seq_d;
      req_cnt_q  <= req_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_push) mem_q[wr_ptr_q] <= resp_word;
  end

  assign ready_o      = ready_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign req_count_o  = req_cnt_q;
  assign err_count_o  = err_cnt_q;
  assign fifo_level_o = level_q;
endmodule

// File: tb/tb_hash_table_stream_wrapper.sv
// Directed bench for hash_table_stream_wrapper; a second instance with 4-bit counters checks saturation.

module tb_hash_table_stream_wrapper;
  logic         clk = 1'b0;
  logic         reset;
  logic [199:0] matrixes;
  logic [31:0]  data_i;
  logic         valid_i, ready_i, clear_stats_i;
  logic         ready_o, valid_o, ready_o_s, valid_o_s;
  logic [63:0]  data_o, data_o_s;
  logic [15:0]  req_count, err_count;
  logic [3:0]   req_count_s, err_count_s;
  logic [2:0]   fifo_level, fifo_level_s;

  int checks = 0;
  int errors = 0;
  int exp_seq = 0;
  logic [63:0] head;

  always #5 clk = ~clk;

  hash_table_stream_wrapper dut (
    .clk(clk), .reset(reset), .matrixes_i(matrixes), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .clear_stats_i(clear_stats_i), .req_count_o(req_count), .err_count_o(err_count),
    .fifo_level_o(fifo_level)
  );

  hash_table_stream_wrapper #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .matrixes_i(matrixes), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o_s), .data_o(data_o_s), .valid_o(valid_o_s), .ready_i(ready_i),
    .clear_stats_i(clear_stats_i), .req_count_o(req_count_s), .err_count_o(err_count_s),
    .fifo_level_o(fifo_level_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] f, input int seq, input logic [24:0] d);
    return {f, 8'(seq), 27'd0, d};
  endfunction

  task automatic send_req(input logic [1:0] op, input logic [4:0] key, input logic [24:0] d);
    int n = 0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = {op, key, d};
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    while (valid_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk(tag, data_o, exp);
    ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
  endtask

  initial begin
    matrixes = '0;
    for (int t = 0; t < 8; t++)
      for (int j = 0; j < 5; j++)
        matrixes[(t*5 + j)*5 + j] = 1'b1;
    reset = 1'b1; valid_i = 1'b1; ready_i = 1'b0; clear_stats_i = 1'b0;
    data_i = {2'b01, 5'h02, 25'h1};

    // Reset held three cycles with valid_i high
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_req", 64'(req_count), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    reset = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 64'(ready_o), 64'd1);

    // Write then read back
    send_req(2'b01, 5'h03, 25'h1ABCDE);
    check_resp("wr3", 64'h0000_0000_0000_0000);
    send_req(2'b00, 5'h03, 25'h0);
    check_resp("rd3", 64'h0010_0000_001A_BCDE);
    chk("req_after_rd3", 64'(req_count), 64'd2);
    chk("err_after_rd3", 64'(err_count), 64'd0);

    // Absent read, delete hit/miss, duplicate write
    send_req(2'b00, 5'h1F, 25'h0);
    check_resp("rd1f", 64'h4020_0000_0000_0000);
    chk("err_after_rd1f", 64'(err_count), 64'd1);
    chk("req_after_rd1f", 64'(req_count), 64'd3);
    send_req(2'b10, 5'h03, 25'h0);
    check_resp("del3", 64'h0030_0000_0000_0000);
    send_req(2'b10, 5'h03, 25'h0);
    check_resp("del3_again", 64'h1040_0000_0000_0000);
    send_req(2'b01, 5'h05, 25'h55);
    check_resp("wr5", 64'h0050_0000_0000_0000);
    send_req(2'b01, 5'h05, 25'h66);
    check_resp("wr5_dup", 64'h8060_0000_0000_0000);
    chk("err_after_dup", 64'(err_count), 64'd3);
    chk("req_after_dup", 64'(req_count), 64'd7);

    // Back-pressure: seven writes fit (4 FIFO, 1 core, 2 skid), the eighth waits
    exp_seq = 7;
    for (int k = 0; k < 7; k++) send_req(2'b01, 5'(8 + k), 25'(32'h100 + k));
    repeat (6) @(negedge clk);
    chk("bp_level", 64'(fifo_level), 64'd4);
    chk("bp_ready", 64'(ready_o), 64'd0);
    chk("bp_valid", 64'(valid_o), 64'd1);
    chk("bp_head", data_o, 64'h0070_0000_0000_0000);
    head = data_o;
    repeat (3) @(negedge clk);
    chk("bp_head_stable", data_o, head);
    chk("bp_req", 64'(req_count), 64'd14);
    check_resp("bp_resp0", mk(4'b0000, exp_seq, 25'h0));
    exp_seq++;
    send_req(2'b01, 5'h0F, 25'h107);
    for (int k = 1; k < 8; k++) begin
      check_resp("bp_resp", mk(4'b0000, exp_seq, 25'h0));
      exp_seq++;
    end
    @(negedge clk);
    chk("bp_level_end", 64'(fifo_level), 64'd0);
    chk("bp_valid_end", 64'(valid_o), 64'd0);
    chk("bp_data_hold", data_o, 64'h00E0_0000_0000_0000);
    chk("bp_req_end", 64'(req_count), 64'd15);
    chk("sat_req_15", 64'(req_count_s), 64'd15);

    // Sequence wrap and counter saturation
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      send_req(2'b00, 5'h1F, 25'h0);
      check_resp("wrap_resp", mk(4'b0100, i % 256, 25'h0));
    end
    chk("wrap_last_word", data_o, 64'h4000_0000_0000_0000);
    chk("wrap_req", 64'(req_count), 64'd257);
    chk("wrap_err", 64'(err_count), 64'd257);
    chk("sat_req", 64'(req_count_s), 64'd15);
    chk("sat_err", 64'(err_count_s), 64'd15);

    // Clear wins over increment on the accepting cycle
    @(negedge clk);
    clear_stats_i = 1'b1; valid_i = 1'b1; data_i = {2'b00, 5'h1F, 25'h0};
    chk("clr_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0; clear_stats_i = 1'b0;
    @(negedge clk);
    chk("clr_req", 64'(req_count), 64'd0);
    chk("clr_sat_req", 64'(req_count_s), 64'd0);
    check_resp("clr_resp", 64'h4010_0000_0000_0000);
    chk("clr_err_after", 64'(err_count), 64'd1);
    chk("clr_req_after", 64'(req_count), 64'd0);

    // Reset in the middle of a burst discards everything
    for (int k = 0; k < 3; k++) send_req(2'b00, 5'h1F, 25'h0);
    repeat (8) @(negedge clk);
    chk("mid_valid", 64'(valid_o), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", 64'(ready_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_valid_after", 64'(valid_o), 64'd0);
    chk("mid_level_after", 64'(fifo_level), 64'd0);
    chk("mid_data_after", data_o, 64'd0);
    chk("mid_req_after", 64'(req_count), 64'd0);
    chk("mid_ready_after", 64'(ready_o), 64'd1);
    send_req(2'b00, 5'h1F, 25'h0);
    check_resp("mid_first_resp", 64'h4000_0000_0000_0000);
    chk("mid_err", 64'(err_count), 64'd1);
    chk("mid_req", 64'(req_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
